// File: rtl/column_win_scanner.sv
// Connect-four style vertical win scanner: drops one piece per accepted move,
// then walks down the column one cell per cycle to measure the same-player run.
module column_win_scanner #(
   parameter int unsigned ROWS    = 6,
   parameter int unsigned COLS    = 7,
   parameter int unsigned WIN_LEN = 4,
   parameter int unsigned COL_W   = 3,
   parameter int unsigned ROW_W   = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   input  logic             move_valid,
   input  logic [COL_W-1:0] move_col,
   input  logic             move_player,
   output logic             move_ready,
   output logic             result_valid,
   output logic             wongame,
   output logic             illegal,
   output logic             draw,
   output logic [ROW_W-1:0] drop_row,
   output logic [ROW_W-1:0] run_len
);

   localparam int unsigned CELLS = ROWS * COLS;
   localparam int unsigned CNT_W = $clog2(CELLS + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PLACE  = 2'd1;
   localparam logic [1:0] S_SCAN   = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [ROWS-1:0]  occ_q [COLS];
   logic [ROWS-1:0]  ply_q [COLS];
   logic [COL_W-1:0] col_q;
   logic             player_q;
   logic [ROW_W-1:0] count_q, count_d, count_inc;
   logic [ROW_W-1:0] ptr_q, ptr_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] filled_q, filled_d;
   logic             over_q, over_d;
   logic             bad_q, bad_d;
   logic             alive_q;
   logic             wr_en, accept;
   logic             rv_d, won_d, ill_d, draw_d;
   logic [ROW_W-1:0] drop_d, run_d;

   logic             col_ok, col_full, found, cell_occ, cell_ply;
   logic [ROWS-1:0]  col_occ, col_ply;
   logic [ROW_W-1:0] free_row;

   // alive_q keeps move_ready low while reset is asserted
   assign move_ready = alive_q && (state_q == S_IDLE) && !clear;
   assign accept     = move_valid && move_ready;

   // Column, landing row and scanned-cell lookup for the captured move
   always_comb begin
      col_ok   = 1'b0;
      col_occ  = '0;
      col_ply  = '0;
      found    = 1'b0;
      free_row = '0;
      cell_occ = 1'b0;
      cell_ply = 1'b0;
      for (int unsigned c = 0; c < COLS; c++) begin
         if (col_q == COL_W'(c)) begin
            col_ok  = 1'b1;
            col_occ = occ_q[c];
            col_ply = ply_q[c];
         end
      end
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (!found && !col_occ[r]) begin
            found    = 1'b1;
            free_row = ROW_W'(r);
         end
         if (ptr_q == ROW_W'(r)) begin
            cell_occ = col_occ[r];
            cell_ply = col_ply[r];
         end
      end
      col_full  = &col_occ;
      count_inc = count_q + ROW_W'(1);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      ptr_d    = ptr_q;
      row_d    = row_q;
      filled_d = filled_q;
      over_d   = over_q;
      bad_d    = bad_q;
      wr_en    = 1'b0;
      rv_d     = 1'b0;
      won_d    = wongame;
      ill_d    = illegal;
      draw_d   = draw;
      drop_d   = drop_row;
      run_d    = run_len;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_PLACE;
         end
         S_PLACE: begin
            if (!col_ok || col_full || over_q) begin
               bad_d   = 1'b1;
               count_d = '0;
               row_d   = '0;
               state_d = S_REPORT;
            end else begin
               bad_d    = 1'b0;
               wr_en    = 1'b1;
               row_d    = free_row;
               count_d  = ROW_W'(1);
               filled_d = filled_q + CNT_W'(1);
               if (free_row == '0) begin
                  state_d = S_REPORT;
               end else begin
                  ptr_d   = free_row - ROW_W'(1);
                  state_d = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            // pieces are contiguous, so a mismatch ends the run
            if (cell_occ && (cell_ply == player_q)) begin
               count_d = count_inc;
               if ((count_inc == ROW_W'(WIN_LEN)) || (ptr_q == '0)) state_d = S_REPORT;
               else ptr_d = ptr_q - ROW_W'(1);
            end else begin
               state_d = S_REPORT;
            end
         end
         default: begin
            rv_d    = 1'b1;
            won_d   = (count_q == ROW_W'(WIN_LEN));
            ill_d   = bad_q;
            draw_d  = (filled_q == CNT_W'(CELLS)) && !won_d;
            drop_d  = row_q;
            run_d   = count_q;
            if (won_d || draw_d) over_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, board and registered outputs; clear overrides everything but reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         alive_q      <= 1'b0;
         col_q        <= '0;
         player_q     <= 1'b0;
         count_q      <= '0;
         ptr_q        <= '0;
         row_q        <= '0;
         filled_q     <= '0;
         over_q       <= 1'b0;
         bad_q        <= 1'b0;
         result_valid <= 1'b0;
         wongame      <= 1'b0;
         illegal      <= 1'b0;
         draw         <= 1'b0;
         drop_row     <= '0;
         run_len      <= '0;
         for (int unsigned c = 0; c < COLS; c++) begin
            occ_q[c] <= '0;
            ply_q[c] <= '0;
         end
      end else begin
         alive_q <= 1'b1;
         if (clear) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            ptr_q        <= '0;
            row_q        <= '0;
            filled_q     <= '0;
            over_q       <= 1'b0;
            bad_q        <= 1'b0;
            result_valid <= 1'b0;
            wongame      <= 1'b0;
            illegal      <= 1'b0;
            draw         <= 1'b0;
            drop_row     <= '0;
            run_len      <= '0;
            for (int unsigned c = 0; c < COLS; c++) begin
               occ_q[c] <= '0;
               ply_q[c] <= '0;
            end
         end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            row_q        <= row_d;
            filled_q     <= filled_d;
            over_q       <= over_d;
            bad_q        <= bad_d;
            result_valid <= rv_d;
            wongame      <= won_d;
            illegal      <= ill_d;
            draw         <= draw_d;
            drop_row     <= drop_d;
            run_len      <= run_d;
            if (accept) begin
               col_q    <= move_col;
               player_q <= move_player;
            end
            if (wr_en) begin
               for (int unsigned c = 0; c < COLS; c++) begin
                  for (int unsigned r = 0; r < ROWS; r++) begin
                     if ((col_q == COL_W'(c)) && (free_row == ROW_W'(r))) begin
                        occ_q[c][r] <= 1'b1;
                        ply_q[c][r] <= player_q;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_column_win_scanner.sv
// Directed bench for column_win_scanner: a table of moves/clears with expected
// results and latencies, plus hand sequences for reset and clear corner cases.
module tb_column_win_scanner;

   logic       clk = 1'b0;
   logic       resetn;
   logic       clear;
   logic       move_valid;
   logic [2:0] move_col;
   logic       move_player;
   logic       move_ready;
   logic       result_valid;
   logic       wongame;
   logic       illegal;
   logic       draw;
   logic [2:0] drop_row;
   logic [2:0] run_len;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit         clr;
      logic [2:0] col;
      logic       pl;
      logic [2:0] row;
      logic [2:0] run;
      logic       win;
      logic       ill;
      logic       drw;
      int         lat;
   } vec_t;

   vec_t vecs[$];
   int   pat_pl [6] = '{1, 1, 0, 0, 1, 1};
   int   pat_run[6] = '{1, 2, 1, 2, 1, 2};
   int   pat_lat[6] = '{2, 3, 3, 4, 3, 4};

   column_win_scanner dut (
      .clk         (clk),
      .resetn      (resetn),
      .clear       (clear),
      .move_valid  (move_valid),
      .move_col    (move_col),
      .move_player (move_player),
      .move_ready  (move_ready),
      .result_valid(result_valid),
      .wongame     (wongame),
      .illegal     (illegal),
      .draw        (draw),
      .drop_row    (drop_row),
      .run_len     (run_len)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic void add(input bit clr, input logic [2:0] col, input logic pl,
                               input logic [2:0] row, input logic [2:0] run, input logic win,
                               input logic ill, input logic drw, input int lat);
      vec_t v;
      v.clr = clr; v.col = col; v.pl = pl; v.row = row; v.run = run;
      v.win = win; v.ill = ill; v.drw = drw; v.lat = lat;
      vecs.push_back(v);
   endfunction

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // Issue one move and count edges after acceptance until result_valid
   task automatic do_move(input logic [2:0] col, input logic pl, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!move_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_before_move", 32'(move_ready), 32'd1);
      move_col    = col;
      move_player = pl;
      move_valid  = 1'b1;
      @(posedge clk);
      #1 move_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!result_valid && lat < 30);
   endtask

   initial begin
      int   lat;
      logic seen;

      resetn = 1'b0; clear = 1'b0; move_valid = 1'b0; move_col = '0; move_player = 1'b0;

      // game A: vertical win in col 2, then illegal, then clear restores play
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 2, 1, 0, 1, 0, 0, 0, 2);
      add(0, 2, 1, 1, 2, 0, 0, 0, 3);
      add(0, 2, 1, 2, 3, 0, 0, 0, 4);
      add(0, 2, 1, 3, 4, 1, 0, 0, 5);
      add(0, 0, 0, 0, 0, 0, 1, 0, 2);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 2, 0, 0, 1, 0, 0, 0, 2);
      // game B: P0 then four P1 in col 0; scan stops on the win
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 2);
      add(0, 0, 1, 1, 1, 0, 0, 0, 3);
      add(0, 0, 1, 2, 2, 0, 0, 0, 4);
      add(0, 0, 1, 3, 3, 0, 0, 0, 5);
      add(0, 0, 1, 4, 4, 1, 0, 0, 5);
      // game C: full column and out-of-range column
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int r = 0; r < 6; r++)
         add(0, 5, logic'(r % 2 == 0), 3'(r), 1, 0, 0, 0, (r == 0) ? 2 : 3);
      add(0, 5, 0, 0, 0, 0, 1, 0, 2);
      add(0, 7, 1, 0, 0, 0, 1, 0, 2);
      add(0, 4, 1, 0, 1, 0, 0, 0, 2);
      // game D: fill the board column by column with runs of at most 2
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++)
            add(0, 3'(c), logic'(pat_pl[r]), 3'(r), 3'(pat_run[r]), 0, 0,
                logic'(c == 6 && r == 5), pat_lat[r]);
      add(0, 0, 1, 0, 0, 0, 1, 1, 2);

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(move_ready), 0);
      chk("rst_outputs", 32'({result_valid, wongame, illegal, draw, drop_row, run_len}), 0);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_reset", 32'(move_ready), 1);

      foreach (vecs[i]) begin
         if (vecs[i].clr) begin
            do_clear();
            chk($sformatf("v%0d_clear_outputs", i),
                32'({result_valid, wongame, illegal, draw, drop_row, run_len}), 0);
         end else begin
            do_move(vecs[i].col, vecs[i].pl, lat);
            chk($sformatf("v%0d_result_valid", i), 32'(result_valid), 1);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            if (!vecs[i].ill) chk($sformatf("v%0d_drop_row", i), 32'(drop_row), 32'(vecs[i].row));
            chk($sformatf("v%0d_run_len", i), 32'(run_len), 32'(vecs[i].run));
            chk($sformatf("v%0d_wongame", i), 32'(wongame), 32'(vecs[i].win));
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("v%0d_draw", i), 32'(draw), 32'(vecs[i].drw));
         end
      end

      // result_valid lasts exactly one cycle
      @(posedge clk);
      #1 chk("rv_one_cycle", 32'(result_valid), 0);

      // reset asserted while scanning aborts the move
      do_clear();
      do_move(3, 1, lat);
      do_move(3, 1, lat);
      @(negedge clk);
      move_col = 3; move_player = 1'b1; move_valid = 1'b1;
      @(posedge clk);
      #1 move_valid = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      chk("midscan_rst_ready", 32'(move_ready), 0);
      chk("midscan_rst_outputs", 32'({result_valid, wongame, illegal, draw, drop_row, run_len}), 0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1 seen |= result_valid;
      end
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1 chk("midscan_ready_after", 32'(move_ready), 1);
      repeat (6) begin
         @(posedge clk);
         #1 seen |= result_valid;
      end
      chk("midscan_no_result", 32'(seen), 0);
      do_move(3, 0, lat);
      chk("midscan_board_empty_row", 32'(drop_row), 0);
      chk("midscan_board_empty_run", 32'(run_len), 1);

      // clear together with move_valid: clear wins
      @(negedge clk);
      clear = 1'b1; move_valid = 1'b1; move_col = 3; move_player = 1'b1;
      #1 chk("clear_blocks_ready", 32'(move_ready), 0);
      @(posedge clk);
      #1 clear = 1'b0;
      move_valid = 1'b0;
      chk("clear_outputs", 32'({result_valid, wongame, illegal, draw, drop_row, run_len}), 0);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1 seen |= result_valid;
      end
      chk("clear_no_result", 32'(seen), 0);
      chk("clear_ready", 32'(move_ready), 1);
      do_move(3, 1, lat);
      chk("clear_board_empty_row", 32'(drop_row), 0);
      chk("clear_board_empty_run", 32'(run_len), 1);
      chk("clear_next_latency", 32'(lat), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
